wb_arbiter_2to1: RTL and testbench
==================================

Name: wb_arbiter_2to1

Overview:
- Arbitrates between the CPU's two Wishbone master ports and a single shared Wishbone slave (SRAM/peripheral bus). Port 0 is instruction fetch; port 1 is data memory.
- Sits directly downstream of the CPU core.
- Round-robin arbitration; the grant is locked for a whole bus cycle (cyc high).
- A watchdog terminates a cycle with an error pulse if the slave never acknowledges.

Parameters:
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width
- TIMEOUT, 255, max cycles a granted strobe may wait for ack before error; must be >= 1

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (IF) cycle/strobe/write
- m0_adr_i  in  ADDR_WIDTH  master 0 address
- m0_dat_i  in  DATA_WIDTH  master 0 write data
- m0_sel_i  in  DATA_WIDTH/8  master 0 byte select
- m0_dat_o  out  DATA_WIDTH  master 0 read data
- m0_ack_o, m0_err_o  out  1 each  master 0 ack/error
- m1_*  same set as m0_*  master 1 (MEM)
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle/strobe/write
- s_adr_o  out  ADDR_WIDTH  slave address
- s_dat_o  out  DATA_WIDTH  slave write data
- s_sel_o  out  DATA_WIDTH/8  slave byte select
- s_dat_i  in  DATA_WIDTH  slave read data
- s_ack_i  in  1  slave ack

Behaviour:

State machine, states IDLE, GNT0, GNT1. Reset state IDLE. Reset is asynchronous and active-low.

Registers and their reset values:
- state = IDLE
- last_grant = 1, so master 0 wins the first tie
- wd_cnt = 0, width $clog2(TIMEOUT+1)
- err_pend = 0

IDLE:
- Slave outputs (cyc, stb, we, adr, dat, sel) are all 0.
- At each edge, requests are sampled:
  - only m0_cyc_i high -> GNT0
  - only m1_cyc_i high -> GNT1
  - both high -> grant the master != last_grant
  - neither -> stay IDLE
- On entering GNTx, last_grant <= x.
- Arbitration latency is 1 cycle from cyc assertion in IDLE to slave cyc assertion.

GNTx:
- s_* outputs are combinationally driven from master x.
- mx_ack_o = s_ack_i; mx_dat_o = s_dat_i.
- The non-granted master sees ack = 0 and err = 0.
- m0_dat_o and m1_dat_o both carry s_dat_i at all times; only ack/err are gated.
- If mx_cyc_i is low at the edge -> IDLE. At least one IDLE cycle is required between grants, even if the other master is waiting.
- Multiple stb/ack transfers within one held cyc stay in GNTx; grant cannot be preempted.

Watchdog:
- In GNTx with s_stb_o=1 and s_ack_i=0, wd_cnt increments each cycle.
- wd_cnt clears on s_ack_i, on stb low, and in IDLE.
- When wd_cnt == TIMEOUT-1 with still no ack:
  - err_pend <= 1 and state -> IDLE.
  - In the next cycle mx_err_o = 1 for exactly one cycle to the master that was granted.
  - Slave outputs are 0 in that cycle (state IDLE).
  - err_pend clears after that one cycle.
- Masters must drop cyc on err. If cyc is still high, the master is simply re-arbitrated.

Simultaneous events:
- Ack arriving in the same cycle the counter reaches TIMEOUT-1: ack wins, no error.
- Reset mid-cycle: all outputs go to 0 immediately (async), state IDLE, and any pending err is discarded.

Outputs:
- All mx_ack_o are combinational.
- mx_err_o is registered-derived.
- No output is X after reset.

Test Plan:
- Reset low mid-GNT1 with s_cyc_o=1 -> s_cyc_o/s_stb_o drop to 0 the same cycle; after release, state IDLE and all m*_ack_o/err_o = 0.
- m0 read of adr 0x8000_0000 alone; slave acks 2 cycles after s_stb_o with s_dat_i=0x00000013 -> s_adr_o=0x8000_0000 one cycle after m0_cyc_i; m0_ack_o=1 with m0_dat_o=0x13; m1_ack_o stays 0.
- Both cyc raised on the same edge after reset -> m0 granted first. On m0 release, IDLE for 1 cycle, then m1 granted. On the next simultaneous request after m1, m0 is granted again (round-robin alternation over 4 rounds).
- m1 write adr 0x8010_0004, dat 0xDEADBEEF, sel 0xF, held through 3 back-to-back acked transfers in one cyc while m0 requests -> m0 is not granted until m1_cyc_i drops; s_we_o=1 and s_sel_o=0xF throughout.
- TIMEOUT=4, m0 strobe with s_ack_i held 0 -> after 4 stalled cycles, s_cyc_o=0 and m0_err_o=1 for exactly one cycle; m1 is not affected.
- TIMEOUT=4 with s_ack_i asserted exactly in the 4th stalled cycle -> m0_ack_o=1, no m0_err_o, grant retained while cyc high.

Source files
------------

// File: rtl/wb_arbiter_2to1.sv
// wb_arbiter_2to1: round-robin 2-master Wishbone arbiter with per-cycle grant lock and ack watchdog.
// Ports: clk, reset (async active-low); m0_* instruction-fetch master, m1_* data master
// (cyc/stb/we/adr/dat/sel in, dat/ack/err out); s_* shared slave (cyc/stb/we/adr/dat/sel out, dat/ack in).
module wb_arbiter_2to1 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i
);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, state_nxt;
  logic last_grant, err_pend, g0, g1, stall, tmo;
  logic [WW-1:0] wd_cnt;
  assign g0    = state == GNT0;
  assign g1    = state == GNT1;
  assign stall = s_stb_o & ~s_ack_i;
  // an ack in the final watchdog cycle clears stall, so ack beats the timeout
  assign tmo   = stall & (wd_cnt == WW'(TIMEOUT - 1));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      wd_cnt     <= '0;
      err_pend   <= 1'b0;
    end else begin
      state    <= state_nxt;
      err_pend <= tmo;
      wd_cnt   <= (stall && !tmo) ? wd_cnt + 1'b1 : '0;
      if (state == IDLE && state_nxt != IDLE) last_grant <= state_nxt == GNT1;
    end
  end
  // a grant is only issued from IDLE, which forces one idle cycle between owners
  always_comb begin
    state_nxt = state;
    if (state == IDLE)
      state_nxt = (m0_cyc_i && (!m1_cyc_i || last_grant)) ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
    else if (tmo || !(g0 ? m0_cyc_i : m1_cyc_i))
      state_nxt = IDLE;
  end
  // err_pend is only ever set while in IDLE, where last_grant still names the timed-out master
  always_comb begin
    s_cyc_o  = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
    s_stb_o  = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
    s_we_o   = g0 ? m0_we_i  : g1 ? m1_we_i  : 1'b0;
    s_adr_o  = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
    s_dat_o  = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
    s_sel_o  = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    m0_ack_o = g0 & s_ack_i;
    m1_ack_o = g1 & s_ack_i;
    m0_err_o = err_pend & ~last_grant;
    m1_err_o = err_pend & last_grant;
  end
endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// tb_wb_arbiter_2to1: directed and randomized checks of wb_arbiter_2to1 against a transaction-level model.
module tb_wb_arbiter_2to1;
  localparam int TO = 4;
  logic clk = 0, reset = 0;
  logic m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0, m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0, s_ack_i = 0;
  logic [31:0] m0_adr_i = 0, m0_dat_i = 0, m1_adr_i = 0, m1_dat_i = 0, s_dat_i = 0;
  logic [3:0] m0_sel_i = 0, m1_sel_i = 0;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic [3:0] s_sel_o;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_cyc_o, s_stb_o, s_we_o;
  int total = 0, bad = 0;
  int owner = -1, last = 1, stall = 0, err_to = -1;
  logic rc0 = 0, rc1 = 0;
  wb_arbiter_2to1 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    owner = -1; last = 1; stall = 0; err_to = -1;
  endtask
  task automatic step(input logic c0, input logic s0, input logic c1, input logic s1, input logic a);
    int ne;
    logic cs, ss;
    @(negedge clk);
    m0_cyc_i = c0; m0_stb_i = s0; m1_cyc_i = c1; m1_stb_i = s1; s_ack_i = a;
    #1;
    chk("s_ctl", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}),
        owner == 0 ? 64'({c0, s0, m0_we_i, m0_sel_i}) : owner == 1 ? 64'({c1, s1, m1_we_i, m1_sel_i}) : 64'd0);
    chk("s_adr", 64'(s_adr_o), owner == 0 ? 64'(m0_adr_i) : owner == 1 ? 64'(m1_adr_i) : 64'd0);
    chk("s_dat", 64'(s_dat_o), owner == 0 ? 64'(m0_dat_i) : owner == 1 ? 64'(m1_dat_i) : 64'd0);
    chk("m_resp", 64'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}),
        64'({owner == 0 && a, err_to == 0, owner == 1 && a, err_to == 1}));
    chk("m_dat", 64'({m0_dat_o, m1_dat_o}), 64'({s_dat_i, s_dat_i}));
    @(posedge clk);
    ne = -1;
    if (owner < 0) begin
      if (c0 && (!c1 || last == 1)) owner = 0;
      else if (c1) owner = 1;
      if (owner >= 0) last = owner;
      stall = 0;
    end else begin
      cs = owner == 0 ? c0 : c1;
      ss = owner == 0 ? s0 : s1;
      if (ss && !a) begin
        stall++;
        if (stall == TO) begin ne = owner; owner = -1; stall = 0; end
      end else stall = 0;
      if (owner >= 0 && !cs) owner = -1;
    end
    err_to = ne;
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_s", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o}), 64'd0);
    chk("rst_m", 64'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 64'd0);
    reset = 1;
    m0_adr_i = 32'h8000_0000; m0_sel_i = 4'hF; s_dat_i = 32'h13;
    step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 1);
    chk("rd_dat", 64'(m0_dat_o), 64'h13);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    m1_adr_i = 32'h4000_0000;
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 1, 1, 0); step(1, 1, 1, 1, 1);
      step(owner != 0, owner != 0, owner != 1, owner != 1, 0);
      step(owner != 0, owner != 0, owner != 1, owner != 1, 1);
      step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    end
    m1_adr_i = 32'h8010_0004; m1_dat_i = 32'hDEAD_BEEF; m1_sel_i = 4'hF; m1_we_i = 1;
    step(0, 0, 1, 1, 0);
    repeat (3) step(1, 1, 1, 1, 1);
    step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 1); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    repeat (TO) step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    repeat (TO - 1) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1); step(1, 1, 0, 0, 0); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0); step(0, 0, 1, 1, 0);
    #2 reset = 0;
    #1;
    chk("arst_s", 64'({s_cyc_o, s_stb_o}), 64'd0);
    chk("arst_m", 64'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 64'd0);
    model_reset();
    @(negedge clk);
    m1_cyc_i = 0; m1_stb_i = 0;
    reset = 1;
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      m0_adr_i = $urandom; m0_dat_i = $urandom; m0_sel_i = 4'($urandom); m0_we_i = 1'($urandom);
      m1_adr_i = $urandom; m1_dat_i = $urandom; m1_sel_i = 4'($urandom); m1_we_i = 1'($urandom);
      s_dat_i = $urandom;
      if ($urandom_range(0, 3) == 0) rc0 = ~rc0;
      if ($urandom_range(0, 3) == 0) rc1 = ~rc1;
      step(rc0, rc0 && $urandom_range(0, 3) != 0, rc1, rc1 && $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
